// File: rtl/rv32i_types.sv
// Shared rv32i types: machine word, cache line geometry and the
// line/burst adaptor state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam int LINE_WIDTH      = 256;
    localparam int BURST_WIDTH     = 64;
    localparam int BURSTS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } ca_state_t;

    // Aligns a byte address down to the start of its 32-byte line.
    function automatic rv32i_word line_base(input rv32i_word addr);
        return addr & ~rv32i_word'(LINE_WIDTH / 8 - 1);
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line request from the arbiter into a 4 x 64-bit
// burst to physical memory, and assembles read beats back into a line.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   line_i, line_o      write line in / assembled read line out
//   address_i           line address from the arbiter
//   read_i, write_i     line requests, held until resp_o
//   resp_o              one-cycle completion pulse
//   burst_i, burst_o    read beat in / write beat out
//   address_o           line-aligned burst base address
//   read_o, write_o     burst requests to memory
//   resp_i              beat strobe from memory
module cacheline_adaptor
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,

    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    ca_state_t            state;
    logic [1:0]           count;
    logic [1:0]           next_count;
    logic [LINE_WIDTH-1:0] line_buf;

    assign next_count = count + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            line_o    <= '0;
            address_o <= '0;
            burst_o   <= '0;
            line_buf  <= '0;
        end else begin
            resp_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Read has priority; a simultaneous write is dropped.
                    if (read_i) begin
                        state     <= READ;
                        read_o    <= 1'b1;
                        address_o <= line_base(address_i);
                        count     <= '0;
                    end else if (write_i) begin
                        state     <= WRITE;
                        write_o   <= 1'b1;
                        address_o <= line_base(address_i);
                        line_buf  <= line_i;
                        // Beat 0 is presented together with write_o.
                        burst_o   <= line_i[BURST_WIDTH-1:0];
                        count     <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[BURST_WIDTH*int'(count) +: BURST_WIDTH]
                            <= burst_i;
                        count <= next_count;
                        if (count == 2'(BURSTS_PER_LINE - 1)) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        count   <= next_count;
                        // Preload the following beat so burst_o always
                        // matches the current count.
                        burst_o <=
                            line_buf[BURST_WIDTH*int'(next_count)
                                     +: BURST_WIDTH];
                        if (count == 2'(BURSTS_PER_LINE - 1)) begin
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected beats and lines are
// queued when a request is issued and checked when the DUT produces them.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int errors = 0;
    int checks = 0;
    int resp_cnt = 0;
    int wr_cycles = 0;

    logic [63:0]  exp_beat[$];
    logic [255:0] exp_resp[$];
    logic [255:0] model_line = '0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable at negedge, outputs reflect this cycle.
    always @(negedge clk) begin
        if (read_o | write_o)
            check("rw_excl", 256'(read_o & write_o), 256'(0));
        if (write_o)
            wr_cycles++;
        if (write_o && resp_i) begin
            if (exp_beat.size() > 0)
                check("burst_o", 256'(burst_o), 256'(exp_beat.pop_front()));
            else
                check("spurious_beat", 256'(write_o), 256'(0));
        end
        if (resp_o) begin
            resp_cnt++;
            if (exp_resp.size() > 0)
                check("line_o", line_o, exp_resp.pop_front());
            else
                check("spurious_resp", 256'(resp_o), 256'(0));
        end
    end

    task automatic txn(input bit rd, input bit wr,
                       input logic [31:0] addr,
                       input logic [255:0] wline,
                       input logic [255:0] rdata,
                       input int gaps[4],
                       input bit drop,
                       input int maxwait);
        int n;
        if (rd) begin
            model_line = rdata;
        end else begin
            for (int b = 0; b < 4; b++)
                exp_beat.push_back(wline[64*b +: 64]);
        end
        exp_resp.push_back(model_line);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        n = 0;
        do begin
            step();
            n++;
        end while (!(read_o || write_o) && n < 10);
        check("accept_lat", 256'(n), 256'(maxwait));
        check("address_o", 256'(address_o), 256'({addr[31:5], 5'b0}));
        check("req_kind", 256'({read_o, write_o}), 256'({rd, !rd}));
        if (drop) begin
            read_i  = 1'b0;
            write_i = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                resp_i  = 1'b0;
                burst_i = 64'hDEAD_BEEF_0BAD_F00D;
                step();
                check("busy_gap", 256'(read_o | write_o), 256'(1));
            end
            resp_i  = 1'b1;
            burst_i = rdata[64*b +: 64];
            step();
        end
        resp_i = 1'b0;
        check("resp_o", 256'(resp_o), 256'(1));
        check("req_o_low", 256'(read_o | write_o), 256'(0));
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    localparam logic [255:0] RD_A = {
        {16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] WR_A = {
        {16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    localparam logic [255:0] JUNK = {4{64'h5555_5555_5555_5555}};
    localparam logic [255:0] RD_B = {
        64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
        64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};
    localparam logic [255:0] RD_C = {
        64'hC0DE_0003_C0DE_0003, 64'hC0DE_0002_C0DE_0002,
        64'hC0DE_0001_C0DE_0001, 64'hC0DE_0000_C0DE_0000};
    localparam logic [255:0] WR_B = {
        64'h9999_0003_9999_0003, 64'h9999_0002_9999_0002,
        64'h9999_0001_9999_0001, 64'h9999_0000_9999_0000};

    initial begin
        int g0[4];
        int gw[4];
        int gd[4];
        int r0;
        int w0;
        g0 = '{0, 0, 0, 0};
        gw = '{0, 1, 2, 0};
        gd = '{1, 0, 0, 1};
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        step();
        step();
        check("rst_read_o",  256'(read_o),    256'(0));
        check("rst_write_o", 256'(write_o),   256'(0));
        check("rst_resp_o",  256'(resp_o),    256'(0));
        check("rst_line_o",  line_o,          256'(0));
        check("rst_addr_o",  256'(address_o), 256'(0));
        check("rst_burst_o", 256'(burst_o),   256'(0));
        rst = 1'b0;
        step();

        // Read, back-to-back beats; resp_o lands four beats after read_o.
        txn(1'b1, 1'b0, 32'h0000_1234, JUNK, RD_A, g0, 1'b0, 1);

        // Write with gaps, then a read queued during DONE.
        step();
        r0 = resp_cnt;
        txn(1'b0, 1'b1, 32'h0000_2000, WR_A, JUNK, gw, 1'b0, 1);
        txn(1'b1, 1'b0, 32'h0000_3010, JUNK, RD_B, g0, 1'b0, 2);
        step();
        check("resp_pulse", 256'(resp_o), 256'(0));
        check("resp_count", 256'(resp_cnt - r0), 256'(2));

        // Reset after two of four read beats.
        read_i    = 1'b1;
        address_i = 32'h0000_0080;
        step();
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = JUNK[64*b +: 64];
            step();
        end
        r0      = resp_cnt;
        resp_i  = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_read_o", 256'(read_o), 256'(0));
        check("mid_rst_line_o", line_o, 256'(0));
        resp_i  = 1'b1;
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        step();
        resp_i = 1'b0;
        check("late_beats", line_o, 256'(0));
        check("no_rst_resp", 256'(resp_cnt - r0), 256'(0));
        model_line = '0;
        txn(1'b1, 1'b0, 32'h0000_0040, JUNK, RD_C, g0, 1'b0, 1);
        step();

        // Both requests at once: read only.
        w0 = wr_cycles;
        r0 = resp_cnt;
        txn(1'b1, 1'b1, 32'h0000_4444, WR_B, RD_B, gw, 1'b0, 1);
        step();
        step();
        check("both_no_write", 256'(wr_cycles - w0), 256'(0));
        check("both_one_resp", 256'(resp_cnt - r0), 256'(1));

        // Stray beats in IDLE.
        r0      = resp_cnt;
        resp_i  = 1'b1;
        burst_i = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stray_idle", 256'({read_o, write_o, resp_o}), 256'(0));
        end
        resp_i = 1'b0;
        check("stray_line", line_o, model_line);
        check("stray_resp", 256'(resp_cnt - r0), 256'(0));

        // Write request dropped after acceptance still completes.
        txn(1'b0, 1'b1, 32'h0000_5FFF, WR_B, JUNK, gd, 1'b1, 1);
        step();
        step();

        check("beats_left", 256'(exp_beat.size()), 256'(0));
        check("resps_left", 256'(exp_resp.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 line_i  input  256  write line from arbiter; sampled at request acceptance.
REQ-005 line_o  output  256  assembled read line to arbiter.
REQ-006 address_i  input  32 (rv32i_word)  line address from arbiter.
REQ-007 read_i  input  1  line read request; held high until resp_o.
REQ-008 write_i  input  1  line write request; held high until resp_o.
REQ-009 resp_o  output  1  one-cycle pulse; transaction complete.
REQ-010 burst_i  input  64  read beat from memory.
REQ-011 burst_o  output  64  write beat to memory.
REQ-012 address_o  output  32 (rv32i_word)  burst base address to memory.
REQ-013 read_o  output  1  burst read request to memory.
REQ-014 write_o  output  1  burst write request to memory.
REQ-015 resp_i  input  1  memory beat strobe; one beat transferred per high cycle.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-017 IDLE: read_i high -> READ; else write_i high -> WRITE; else stay. Read wins if both are high, and the write is not performed.
REQ-018 On acceptance, SHALL latch the address as {address_i[31:5], 5'b0}. On a write, SHALL also latch line_i. The beat counter SHALL be cleared.
REQ-019 address_o SHALL be driven from the latched address and stay constant for the whole burst.
REQ-020 READ: read_o=1. On each cycle with resp_i=1, SHALL store burst_i into beat[count] and increment count.
REQ-021 WRITE: write_o=1 and burst_o=latched_line[64*count +: 64]. Each cycle with resp_i=1 SHALL increment count.
REQ-022 Beat order is fixed: beat 0 = bits [63:0], beat 3 = bits [255:192].
REQ-023 count is 2 bits. resp_i with count==3 SHALL move the FSM to DONE; read_o/write_o go low in DONE.
REQ-024 resp_i gaps (low cycles between beats) SHALL be tolerated. count holds while resp_i=0, and there is no timeout.
REQ-025 DONE: resp_o=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-026 line_o SHALL be registered. It is updated only by read beats and holds its value after DONE until the next read overwrites it.
REQ-027 Latency with back-to-back beats: accept at cycle 0, read_o/write_o high from cycle 1, beats at cycles 1-4, resp_o at cycle 5.
REQ-028 A new request present in the IDLE cycle after DONE SHALL be accepted with no extra idle cycle.
REQ-029 resp_i while in IDLE or DONE SHALL be ignored.
REQ-030 read_o and write_o SHALL never be high in the same cycle.
REQ-031 A request deasserted mid-burst SHALL NOT abort the burst; the FSM completes all 4 beats.

Reset
REQ-032 rst SHALL force the FSM to IDLE and count to 0, and drive read_o=0, write_o=0, resp_o=0 from the next cycle.
REQ-033 line_o, address_o and burst_o SHALL reset to 0.
REQ-034 A rst asserted mid-burst SHALL abandon the burst, with no resp_o for it. Beats arriving after reset SHALL be ignored.

Structure
REQ-035 LINE_WIDTH=256, BURST_WIDTH=64, BURSTS_PER_LINE=4 and the FSM state enum SHALL live in the shared rv32i types package alongside rv32i_word.
REQ-036 The block SHALL be a single module with no sub-module; it is instantiated between the arbiter pmem port and physical memory.

Verification
REQ-037 Read, consecutive beats: address_i=0x0000_1234, beats 0x11..11 / 0x22..22 / 0x33..33 / 0x44..44 -> address_o=0x0000_1220, resp_o at cycle 5, line_o={44..,33..,22..,11..}.
REQ-038 Write with gaps: line_i={0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}, resp_i pattern 1,0,1,0,0,1,1 -> burst_o AA, BB, CC, DD in order, write_o low after the 4th beat, a single resp_o pulse.
REQ-039 Write immediately followed by read at the next IDLE cycle -> read_o asserted the cycle after acceptance, no lost request, line_o updated only by the read.
REQ-040 rst asserted after 2 of 4 read beats -> read_o=0 the next cycle, no resp_o; a following read of 0x0000_0040 completes normally with fresh data.
REQ-041 read_i=write_i=1 in IDLE -> read performed, write_o never high, exactly one resp_o.
REQ-042 Stray resp_i=1 in IDLE -> no state change, no resp_o, line_o unchanged.
